// File: rtl/fifo_param_if.sv
// Handshake/data bundle between a producer/consumer and the fifo_param queue.
// The master side drives requests and write data; the slave (the FIFO) returns data and status.
interface fifo_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              wren;
  logic [WIDTH-1:0]  din;
  logic              rden;
  logic [WIDTH-1:0]  dout;
  logic              flush;
  logic              clr_err;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wren, din, rden, flush, clr_err,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wren, din, rden, flush, clr_err,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised show-ahead FIFO with a full-range occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input logic        clk,
  input logic        reset_n,
  fifo_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [ADDR_W-1:0] ptr_t;

  localparam cnt_t AF_CNT    = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_CNT    = cnt_t'(AE_LEVEL);
  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
  localparam ptr_t PTR_ONE   = ptr_t'(1);

  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_levels
      $error("fifo_param: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t raddr_q, raddr_d;
  ptr_t waddr_q, waddr_d;
  cnt_t count_q, count_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic aempty_q, aempty_d;
  logic afull_q, afull_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  logic wr_ok;
  logic rd_ok;

  // A read while full frees a slot, so a simultaneous write is accepted; there is no empty bypass.
  assign wr_ok = bus.wren && (!full_q || bus.rden);
  assign rd_ok = bus.rden && !empty_q;

  always_comb begin
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.flush) begin
      raddr_d = '0;
      waddr_d = '0;
      count_d = '0;
    end else begin
      if (wr_ok) waddr_d = waddr_q + PTR_ONE;
      if (rd_ok) raddr_d = raddr_q + PTR_ONE;
      count_d = count_q + cnt_t'(wr_ok) - cnt_t'(rd_ok);
      ovf_d   = (ovf_q && !bus.clr_err) || (bus.wren && full_q && !bus.rden);
      udf_d   = (udf_q && !bus.clr_err) || (bus.rden && empty_q);
    end
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_CNT);
    aempty_d = (count_d <= AE_CNT);
    afull_d  = (count_d >= AF_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raddr_q  <= '0;
      waddr_q  <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) mem_q[waddr_q] <= bus.din;
  end

  assign bus.dout         = mem_q[raddr_q];
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus a randomized run
// against a queue-based reference model of the FIFO's observable behaviour.
module tb_fifo_param;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int AF     = 28;
  localparam int AE     = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  fifo_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int nCompared = 0;
  int nMismatched = 0;

  logic [WIDTH-1:0] refQ[$];
  bit refOvf = 1'b0;
  bit refUdf = 1'b0;

  // Drives one cycle of requests, advances the reference model at the edge, then settles.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [WIDTH-1:0] d,
                               input bit fl, input bit ce);
    bit isFull;
    bit isEmpty;
    bit ovfNow;
    bit udfNow;
    bus.wren = wr; bus.rden = rd; bus.din = d; bus.flush = fl; bus.clr_err = ce;
    @(posedge clk);
    if (fl) begin
      refQ.delete();
    end else begin
      isFull  = (refQ.size() == DEPTH);
      isEmpty = (refQ.size() == 0);
      ovfNow  = wr && isFull && !rd;
      udfNow  = rd && isEmpty;
      refOvf  = (refOvf && !ce) || ovfNow;
      refUdf  = (refUdf && !ce) || udfNow;
      if (rd && !isEmpty) void'(refQ.pop_front());
      if (wr && !ovfNow) refQ.push_back(d);
    end
    #1;
    bus.wren = 1'b0; bus.rden = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    bus.wren = 1'b0; bus.rden = 1'b0; bus.din = '0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    reset_n = 1'b0;
    #12;
    nCompared++; if (bus.count !== 6'd0) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    nCompared++; if (bus.empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); end
    nCompared++; if (bus.full !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
    nCompared++; if (bus.almost_empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ae: got %b expected 1", bus.almost_empty); end
    nCompared++; if (bus.almost_full !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_af: got %b expected 0", bus.almost_full); end
    nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.overflow); end
    nCompared++; if (bus.underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_udf: got %b expected 0", bus.underflow); end
    refQ.delete(); refOvf = 1'b0; refUdf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
      nCompared++; if (bus.count !== 6'(i + 1)) begin nMismatched++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i + 1); end
      nCompared++; if (bus.almost_full !== (i + 1 >= AF)) begin nMismatched++; $display("[TB] FAIL fill_af[%0d]: got %b expected %b", i, bus.almost_full, (i + 1 >= AF)); end
      nCompared++; if (bus.full !== (i + 1 == DEPTH)) begin nMismatched++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, bus.full, (i + 1 == DEPTH)); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      nCompared++; if (bus.dout !== WIDTH'(i)) begin nMismatched++; $display("[TB] FAIL drain_dout[%0d]: got %0h expected %0h", i, bus.dout, i); end
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      nCompared++; if (bus.empty !== (i == DEPTH - 1)) begin nMismatched++; $display("[TB] FAIL drain_empty[%0d]: got %b expected %b", i, bus.empty, (i == DEPTH - 1)); end
      nCompared++; if (bus.almost_empty !== (DEPTH - 1 - i <= AE)) begin nMismatched++; $display("[TB] FAIL drain_ae[%0d]: got %b expected %b", i, bus.almost_empty, (DEPTH - 1 - i <= AE)); end
    end
    nCompared++; if (bus.count !== 6'd0) begin nMismatched++; $display("[TB] FAIL drain_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_full_both();
    logic [WIDTH-1:0] expD;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
    nCompared++; if (bus.dout !== 32'h0) begin nMismatched++; $display("[TB] FAIL fullboth_head: got %0h expected 0", bus.dout); end
    applyStimulus(1'b1, 1'b1, 32'hAA, 1'b0, 1'b0);
    nCompared++; if (bus.count !== 6'd32) begin nMismatched++; $display("[TB] FAIL fullboth_count: got %0d expected 32", bus.count); end
    nCompared++; if (bus.full !== 1'b1) begin nMismatched++; $display("[TB] FAIL fullboth_full: got %b expected 1", bus.full); end
    nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL fullboth_ovf: got %b expected 0", bus.overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      expD = (i < DEPTH - 1) ? WIDTH'(i + 1) : 32'hAA;
      nCompared++; if (bus.dout !== expD) begin nMismatched++; $display("[TB] FAIL fullboth_dout[%0d]: got %0h expected %0h", i, bus.dout, expD); end
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    nCompared++; if (bus.empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL fullboth_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_empty_both();
    applyStimulus(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
    nCompared++; if (bus.count !== 6'd1) begin nMismatched++; $display("[TB] FAIL emptyboth_count: got %0d expected 1", bus.count); end
    nCompared++; if (bus.empty !== 1'b0) begin nMismatched++; $display("[TB] FAIL emptyboth_empty: got %b expected 0", bus.empty); end
    nCompared++; if (bus.underflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL emptyboth_udf: got %b expected 1", bus.underflow); end
    nCompared++; if (bus.dout !== 32'h55) begin nMismatched++; $display("[TB] FAIL emptyboth_dout: got %0h expected 55", bus.dout); end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    nCompared++; if (bus.underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL clrerr_udf: got %b expected 0", bus.underflow); end
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    // Setting and clearing in the same cycle must leave the flag set.
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1);
    nCompared++; if (bus.underflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL setwins_udf: got %b expected 1", bus.underflow); end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i + 'h100), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hBB, 1'b0, 1'b0);
    nCompared++; if (bus.overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_flag: got %b expected 1", bus.overflow); end
    nCompared++; if (bus.count !== 6'd32) begin nMismatched++; $display("[TB] FAIL ovf_count: got %0d expected 32", bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      nCompared++; if (bus.dout !== WIDTH'(i + 'h100)) begin nMismatched++; $display("[TB] FAIL ovf_dout[%0d]: got %0h expected %0h", i, bus.dout, i + 'h100); end
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    nCompared++; if (bus.overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_clr: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i + 'h40), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h99, 1'b1, 1'b0);
    nCompared++; if (bus.count !== 6'd0) begin nMismatched++; $display("[TB] FAIL flush_count: got %0d expected 0", bus.count); end
    nCompared++; if (bus.empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_empty: got %b expected 1", bus.empty); end
    nCompared++; if (bus.almost_empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_ae: got %b expected 1", bus.almost_empty); end
    applyStimulus(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
    nCompared++; if (bus.dout !== 32'h77) begin nMismatched++; $display("[TB] FAIL flush_next_dout: got %0h expected 77", bus.dout); end
    nCompared++; if (bus.count !== 6'd1) begin nMismatched++; $display("[TB] FAIL flush_next_count: got %0d expected 1", bus.count); end
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit wr;
    bit rd;
    bit fl;
    bit ce;
    int wrPct;
    for (int i = 0; i < 1000; i++) begin
      // Alternate write-heavy and read-heavy phases so the queue sweeps its whole range.
      wrPct = ((i % 200) < 100) ? 75 : 30;
      wr = ($urandom_range(0, 99) < wrPct);
      rd = ($urandom_range(0, 99) < 100 - wrPct);
      fl = ($urandom_range(0, 149) == 0);
      ce = ($urandom_range(0, 24) == 0);
      applyStimulus(wr, rd, WIDTH'($urandom), fl, ce);
      nCompared++; if (bus.count !== 6'(refQ.size())) begin nMismatched++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, bus.count, refQ.size()); end
      nCompared++; if (bus.empty !== (refQ.size() == 0)) begin nMismatched++; $display("[TB] FAIL rnd_empty[%0d]: got %b expected %b", i, bus.empty, (refQ.size() == 0)); end
      nCompared++; if (bus.full !== (refQ.size() == DEPTH)) begin nMismatched++; $display("[TB] FAIL rnd_full[%0d]: got %b expected %b", i, bus.full, (refQ.size() == DEPTH)); end
      nCompared++; if (bus.almost_empty !== (refQ.size() <= AE)) begin nMismatched++; $display("[TB] FAIL rnd_ae[%0d]: got %b expected %b", i, bus.almost_empty, (refQ.size() <= AE)); end
      nCompared++; if (bus.almost_full !== (refQ.size() >= AF)) begin nMismatched++; $display("[TB] FAIL rnd_af[%0d]: got %b expected %b", i, bus.almost_full, (refQ.size() >= AF)); end
      nCompared++; if (bus.overflow !== refOvf) begin nMismatched++; $display("[TB] FAIL rnd_ovf[%0d]: got %b expected %b", i, bus.overflow, refOvf); end
      nCompared++; if (bus.underflow !== refUdf) begin nMismatched++; $display("[TB] FAIL rnd_udf[%0d]: got %b expected %b", i, bus.underflow, refUdf); end
      if (refQ.size() > 0) begin
        nCompared++; if (bus.dout !== refQ[0]) begin nMismatched++; $display("[TB] FAIL rnd_dout[%0d]: got %0h expected %0h", i, bus.dout, refQ[0]); end
      end
      if (i == 600) begin
        #2 reset_n = 1'b0;
        #1;
        nCompared++; if (bus.count !== 6'd0) begin nMismatched++; $display("[TB] FAIL midreset_count: got %0d expected 0", bus.count); end
        nCompared++; if (bus.empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_empty: got %b expected 1", bus.empty); end
        nCompared++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_err: got %b%b expected 00", bus.overflow, bus.underflow); end
        refQ.delete(); refOvf = 1'b0; refUdf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_both();
    test_empty_both();
    test_overflow();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
